// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants: FSM state encoding, preamble/SFD bytes,
// CRC-32 parameters and header field lengths. No ports.
package eth_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    PREAMBLE = 4'd1,
    DEST     = 4'd2,
    SRC      = 4'd3,
    TYPE     = 4'd4,
    DATA     = 4'd5,
    FCS      = 4'd6,
    DRAIN    = 4'd7
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  localparam int DEST_LEN = 6;
  localparam int SRC_LEN  = 6;
  localparam int TYPE_LEN = 2;
  localparam int FCS_LEN  = 4;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide step of the reflected IEEE 802.3 CRC-32 (LSB of the byte first).
// Ports:
//   crc_in  - running CRC register before this byte
//   data    - byte to fold in
//   crc_out - running CRC register after this byte
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Byte is XORed into the low end, then eight reflected shift/reduce steps.
  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
  end

endmodule

// File: rtl/frame_reception.sv
// MAC receive path: hunts preamble/SFD on a byte stream, deserialises
// dest/src/EtherType/fixed payload, checks the trailing CRC-32 FCS.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rx_data, rx_dv      - received byte and byte-valid/frame envelope
//   dest_addr, src_addr - addresses, first byte received is MSB
//   eth_type, data_out  - EtherType and payload, first byte received is MSB
//   rx_valid            - 1-cycle pulse, frame complete and FCS good
//   crc_err             - 1-cycle pulse, frame complete and FCS bad
//   frame_err           - 1-cycle pulse, rx_dv dropped mid-frame
//   addr_match          - dest_addr is MAC_ADDR or broadcast
//   state               - current FSM state (debug)
module frame_reception
  import eth_pkg::*;
#(
  parameter int          PAYLOAD_BYTES = 4,
  parameter logic [47:0] MAC_ADDR      = 48'h123456789ABC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_dv,
  output logic [47:0]                dest_addr,
  output logic [47:0]                src_addr,
  output logic [15:0]                eth_type,
  output logic [8*PAYLOAD_BYTES-1:0] data_out,
  output logic                       rx_valid,
  output logic                       crc_err,
  output logic                       frame_err,
  output logic                       addr_match,
  output logic [3:0]                 state
);

  localparam int DW = 8 * PAYLOAD_BYTES;

  state_t      cur, nxt;
  logic [15:0] cnt, last_cnt;
  logic [31:0] crc, crc_next, rx_fcs, fcs_next;
  logic        take, cnt_clr, crc_clr, valid_n, crcerr_n, ferr_n;

  crc32_d8 u_crc (.crc_in(crc), .data(rx_data), .crc_out(crc_next));

  // FCS arrives least-significant byte first, so bytes enter at the top.
  assign fcs_next   = {rx_data, rx_fcs[31:8]};
  assign state      = cur;
  assign addr_match = (dest_addr == MAC_ADDR) || (dest_addr == 48'hFFFF_FFFF_FFFF);

  always_comb begin
    case (cur)
      DEST:    last_cnt = 16'(DEST_LEN - 1);
      SRC:     last_cnt = 16'(SRC_LEN - 1);
      TYPE:    last_cnt = 16'(TYPE_LEN - 1);
      DATA:    last_cnt = 16'(PAYLOAD_BYTES - 1);
      FCS:     last_cnt = 16'(FCS_LEN - 1);
      default: last_cnt = 16'd0;
    endcase
  end

  always_comb begin
    nxt      = cur;
    take     = 1'b0;
    cnt_clr  = 1'b0;
    crc_clr  = 1'b0;
    valid_n  = 1'b0;
    crcerr_n = 1'b0;
    ferr_n   = 1'b0;
    case (cur)
      IDLE:
        if (rx_dv && rx_data == PREAMBLE_BYTE) nxt = PREAMBLE;
      PREAMBLE:
        if (!rx_dv) nxt = IDLE;
        else if (rx_data == SFD_BYTE) begin
          nxt     = DEST;
          cnt_clr = 1'b1;
          crc_clr = 1'b1;
        end else if (rx_data != PREAMBLE_BYTE) nxt = IDLE;
      DEST, SRC, TYPE, DATA, FCS:
        if (!rx_dv) begin
          // A gap inside the frame is an error, never a stall.
          nxt    = IDLE;
          ferr_n = 1'b1;
        end else begin
          take = 1'b1;
          if (cnt == last_cnt) begin
            cnt_clr = 1'b1;
            case (cur)
              DEST:    nxt = SRC;
              SRC:     nxt = TYPE;
              TYPE:    nxt = DATA;
              DATA:    nxt = FCS;
              default: begin
                nxt      = DRAIN;
                valid_n  = (fcs_next == ~crc);
                crcerr_n = (fcs_next != ~crc);
              end
            endcase
          end
        end
      DRAIN:
        if (!rx_dv) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= IDLE;
      cnt       <= '0;
      crc       <= CRC_INIT;
      rx_fcs    <= '0;
      dest_addr <= '0;
      src_addr  <= '0;
      eth_type  <= '0;
      data_out  <= '0;
      rx_valid  <= 1'b0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cur       <= nxt;
      rx_valid  <= valid_n;
      crc_err   <= crcerr_n;
      frame_err <= ferr_n;

      if (cnt_clr)   cnt <= '0;
      else if (take) cnt <= cnt + 16'd1;

      // CRC covers dest through payload; the FCS bytes themselves are excluded.
      if (crc_clr)                   crc <= CRC_INIT;
      else if (take && cur != FCS)   crc <= crc_next;

      if (take) begin
        case (cur)
          DEST:    dest_addr <= 48'({dest_addr, rx_data});
          SRC:     src_addr  <= 48'({src_addr, rx_data});
          TYPE:    eth_type  <= 16'({eth_type, rx_data});
          DATA:    data_out  <= DW'({data_out, rx_data});
          FCS:     rx_fcs    <= fcs_next;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_reception.sv
module tb_frame_reception;
  localparam int          P   = 4;
  localparam logic [47:0] MAC = 48'h123456789ABC;
  localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;

  logic             clk = 1'b0, rst = 1'b1, rx_dv = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic [47:0]      dest_addr, src_addr;
  logic [15:0]      eth_type;
  logic [8*P-1:0]   data_out;
  logic             rx_valid, crc_err, frame_err, addr_match;
  logic [3:0]       state;

  int total = 0, bad = 0;

  frame_reception #(.PAYLOAD_BYTES(P), .MAC_ADDR(MAC)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_dv(rx_dv),
    .dest_addr(dest_addr), .src_addr(src_addr), .eth_type(eth_type),
    .data_out(data_out), .rx_valid(rx_valid), .crc_err(crc_err),
    .frame_err(frame_err), .addr_match(addr_match), .state(state)
  );

  always #5 clk = ~clk;

  // ev: 0 none, 1 rx_valid, 2 crc_err, 3 frame_err ; est: expected state or -1
  typedef struct {
    bit rst; bit dv; logic [7:0] d; int ev; int est;
    logic [47:0] ed, es; logic [15:0] et; logic [8*P-1:0] ep;
  } item_t;
  item_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic item_t mk(input bit r, input bit v, input logic [7:0] d);
    item_t it;
    it.rst = r; it.dv = v; it.d = d; it.ev = 0; it.est = -1;
    it.ed = '0; it.es = '0; it.et = '0; it.ep = '0;
    return it;
  endfunction

  // mode: 0 good, 1 last payload byte flipped after FCS computed, 2 rx_dv drop
  // at body index cut, 3 body only (no preamble/SFD), 4 reset at body index cut
  task automatic add_frame(input int pre, input logic [47:0] d, input logic [47:0] s,
                           input logic [15:0] t, input logic [8*P-1:0] pl,
                           input int mode, input int cut, input int trail, input int gap);
    logic [7:0]     body[$];
    logic [31:0]    c;
    logic [8*P-1:0] plx;
    item_t          it;
    int             n;
    bit             stop;
    for (int i = 0; i < 6; i++) body.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) body.push_back(s[47-8*i -: 8]);
    for (int i = 0; i < 2; i++) body.push_back(t[15-8*i -: 8]);
    for (int i = 0; i < P; i++) body.push_back(pl[8*P-1-8*i -: 8]);
    // bit-serial reference CRC over the whole header+payload
    c = 32'hFFFF_FFFF;
    foreach (body[i])
      for (int b = 0; b < 8; b++) begin
        bit fb;
        fb = c[0] ^ body[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    c   = ~c;
    plx = pl;
    if (mode == 1) begin
      body[13+P] = body[13+P] ^ 8'h01;
      plx[0]     = ~plx[0];
    end
    for (int i = 0; i < 4; i++) body.push_back(c[8*i +: 8]);
    if (mode != 3) begin
      for (int i = 0; i < pre; i++) q.push_back(mk(1'b0, 1'b1, 8'h55));
      q.push_back(mk(1'b0, 1'b1, 8'hD5));
    end
    n    = body.size();
    stop = 1'b0;
    for (int i = 0; i < n && !stop; i++) begin
      if (mode == 2 && i == cut) begin
        it = mk(1'b0, 1'b0, 8'h00); it.ev = 3; it.est = 0;
        q.push_back(it); stop = 1'b1;
      end else if (mode == 4 && i == cut) begin
        for (int r = 0; r < 2; r++) q.push_back(mk(1'b1, 1'b1, 8'($urandom)));
        stop = 1'b1;
      end else begin
        it = mk(1'b0, 1'b1, body[i]);
        if (i == n - 1 && mode <= 1) begin
          it.ev = (mode == 1) ? 2 : 1;
          it.ed = d; it.es = s; it.et = t; it.ep = plx;
        end
        q.push_back(it);
      end
    end
    if (mode <= 1)
      for (int i = 0; i < trail; i++) q.push_back(mk(1'b0, 1'b1, 8'($urandom)));
    for (int g = 0; g < gap; g++) begin
      it = mk(1'b0, 1'b0, 8'h00);
      if (g == gap - 1) it.est = 0;
      q.push_back(it);
    end
  endtask

  task automatic run_items();
    item_t it;
    while (q.size() > 0) begin
      it      = q.pop_front();
      rst     = it.rst;
      rx_dv   = it.dv;
      rx_data = it.d;
      @(posedge clk);
      #1;
      chk("rx_valid",  64'(rx_valid),  64'(it.ev == 1));
      chk("crc_err",   64'(crc_err),   64'(it.ev == 2));
      chk("frame_err", 64'(frame_err), 64'(it.ev == 3));
      if (it.ev == 1 || it.ev == 2) begin
        chk("dest_addr", 64'(dest_addr), 64'(it.ed));
        chk("src_addr",  64'(src_addr),  64'(it.es));
        chk("eth_type",  64'(eth_type),  64'(it.et));
        chk("data_out",  64'(data_out),  64'(it.ep));
      end
      if (it.ev == 1)
        chk("addr_match", 64'(addr_match), 64'((it.ed == MAC) || (it.ed == BC)));
      if (it.est >= 0)
        chk("state", 64'(state), 64'(it.est));
      if (it.rst) begin
        chk("rst_state", 64'(state),      64'd0);
        chk("rst_dest",  64'(dest_addr),  64'd0);
        chk("rst_src",   64'(src_addr),   64'd0);
        chk("rst_type",  64'(eth_type),   64'd0);
        chk("rst_data",  64'(data_out),   64'd0);
        chk("rst_match", 64'(addr_match), 64'd0);
      end
    end
    rst   = 1'b0;
    rx_dv = 1'b0;
  endtask

  initial begin
    item_t it;
    logic [47:0] rd;
    int mode;
    // power-on reset
    q.push_back(mk(1'b1, 1'b0, 8'h00));
    q.push_back(mk(1'b1, 1'b0, 8'h00));
    // golden frame
    add_frame(7, MAC, 48'hABCDEF123456, 16'h0800, 32'hDEADBEEF, 0, 0, 0, 1);
    // payload EF -> EE after FCS computed
    add_frame(7, MAC, 48'hABCDEF123456, 16'h0800, 32'hDEADBEEF, 1, 0, 0, 1);
    // rx_dv drop in place of the 4th source byte
    add_frame(7, MAC, 48'hABCDEF123456, 16'h0800, 32'hDEADBEEF, 2, 9, 0, 1);
    // 55 55 A5 aborts the hunt; following frame bytes carry no SFD
    q.push_back(mk(1'b0, 1'b1, 8'h55));
    q.push_back(mk(1'b0, 1'b1, 8'h55));
    it = mk(1'b0, 1'b1, 8'hA5); it.est = 0; q.push_back(it);
    q.push_back(mk(1'b0, 1'b1, 8'hD5));
    add_frame(0, MAC, 48'hABCDEF123456, 16'h0800, 32'hDEADBEEF, 3, 0, 0, 1);
    // back-to-back with one idle cycle, second broadcast
    add_frame(7, MAC, 48'hABCDEF123456, 16'h0800, 32'hDEADBEEF, 0, 0, 2, 1);
    add_frame(7, BC,  48'hABCDEF123456, 16'h0800, 32'h01020304, 0, 0, 0, 1);
    // reset during payload, then a clean frame
    add_frame(7, MAC, 48'hABCDEF123456, 16'h0800, 32'hDEADBEEF, 4, 15, 0, 1);
    add_frame(7, MAC, 48'hABCDEF123456, 16'h0800, 32'hDEADBEEF, 0, 0, 0, 1);
    // randomized frames
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 2))
        0:       rd = MAC;
        1:       rd = BC;
        default: rd = {16'($urandom), $urandom};
      endcase
      mode = int'($urandom_range(0, 2));
      add_frame(int'($urandom_range(1, 8)), rd, {16'($urandom), $urandom},
                16'($urandom), 32'($urandom), mode,
                int'($urandom_range(0, 17 + P)), int'($urandom_range(0, 2)),
                int'($urandom_range(1, 3)));
    end
    run_items();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
